// File: rtl/obus_out_arb.sv
// Round-robin arbiter of NREQ requesters onto the obusOut request bus, with hold-until-accepted and replay/retry.
// Optional stall watchdog output wdog_err is built in when OBUS_ARB_WDOG_EN is defined.
module obus_out_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 82,
    parameter int unsigned RETRY_MAX = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      obusOut,
    output logic                  obusOut_want,
    input  logic                  obusOut_can,
    input  logic                  obusOut_replay,
    output logic                  drop_err,
`ifdef OBUS_ARB_WDOG_EN
    output logic                  wdog_err,
`endif
    output logic                  busy
);

    localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RETRY_W = 4;

    localparam logic [PTR_W:0]     NREQ_C   = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NREQ - 1);
    localparam logic [RETRY_W-1:0] RETRY_C  = RETRY_W'(RETRY_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     hold_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [RETRY_W-1:0]   retry_q;

    logic [WIDTH-1:0]     req_word [NREQ];
    logic [PTR_W:0]       cand;
    logic [PTR_W-1:0]     win_idx;
    logic                 any_valid;
    logic                 do_grant;
    logic                 do_retry;
    logic                 do_drop;

    // Unpack the flat payload bus into one word per requester
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_word[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search from rr_ptr; scanning downward lets the closest candidate win
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
            if (req_valid[cand[PTR_W-1:0]]) begin
                any_valid = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; CHECK falls through to the IDLE grant rule on completion or drop
    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_retry = 1'b0;
        do_drop  = 1'b0;
        case (state_q)
            IDLE: begin
                do_grant = any_valid;
            end
            SEND: begin
                if (obusOut_can) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (obusOut_replay && (retry_q < RETRY_C)) begin
                    do_retry = 1'b1;
                    state_d  = SEND;
                end else begin
                    do_drop  = obusOut_replay;
                    do_grant = any_valid;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (do_grant) begin
            state_d = SEND;
        end
    end

    // Outputs decoded in the grant/drop cycle itself
    always_comb begin
        req_ready = '0;
        drop_err  = 1'b0;
        if (rst && do_grant) begin
            req_ready = NREQ'(1) << win_idx;
        end
        if (rst) begin
            drop_err = do_drop;
        end
    end

    // Holding register, round-robin pointer and replay counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q   <= '0;
            rr_ptr_q <= '0;
            retry_q  <= '0;
        end else if (do_grant) begin
            hold_q   <= req_word[win_idx];
            rr_ptr_q <= (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
            retry_q  <= '0;
        end else if (do_retry) begin
            retry_q  <= retry_q + RETRY_W'(1);
        end
    end

    assign obusOut      = hold_q;
    assign obusOut_want = (state_q == SEND);
    assign busy         = (state_q != IDLE);

`ifdef OBUS_ARB_WDOG_EN
    localparam int unsigned    WDOG_W     = 8;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(200);

    logic [WDOG_W-1:0] stall_q;
    logic              wdog_q;
    logic              stall_c;
    logic              wdog_hit;

    assign stall_c  = (state_q == SEND) && !obusOut_can;
    assign wdog_hit = stall_c && (stall_q == WDOG_LIMIT - WDOG_W'(1));

    // Counts consecutive stalled SEND cycles; any non-stall cycle clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            wdog_q  <= 1'b0;
        end else begin
            if (!stall_c) begin
                stall_q <= '0;
            end else if (stall_q != WDOG_LIMIT) begin
                stall_q <= stall_q + WDOG_W'(1);
            end
            if (wdog_hit) begin
                wdog_q <= 1'b1;
            end
        end
    end

    // Raised during the 200th stalled cycle, then held until reset
    assign wdog_err = wdog_q | wdog_hit;
`endif

endmodule

// File: tb/tb_obus_out_arb.sv
// Scoreboard bench for obus_out_arb: stimulus queues expected grants/transfers/drops, a negedge monitor checks them.
module tb_obus_out_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 82;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      obusOut;
    logic                  obusOut_want;
    logic                  obusOut_can;
    logic                  obusOut_replay;
    logic                  drop_err;
    logic                  busy;
`ifdef OBUS_ARB_WDOG_EN
    logic                  wdog_err;
`endif

    int total = 0;
    int bad   = 0;
    int grants_seen = 0;

    logic [WIDTH-1:0] pl [NREQ];
    logic [WIDTH-1:0] exp_xfer_q [$];
    int               exp_grant_q [$];
    int               exp_drop_q [$];
    int               mg;
    logic [WIDTH-1:0] mp;

    obus_out_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .RETRY_MAX(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .obusOut        (obusOut),
        .obusOut_want   (obusOut_want),
        .obusOut_can    (obusOut_can),
        .obusOut_replay (obusOut_replay),
        .drop_err       (drop_err),
`ifdef OBUS_ARB_WDOG_EN
        .wdog_err       (wdog_err),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT grants, transfers, or drops
    always @(negedge clk) begin
        if (rst) begin
            if (req_ready != '0) begin
                grants_seen++;
                if (exp_grant_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant: unexpected req_ready=%b", req_ready);
                end else begin
                    mg = exp_grant_q.pop_front();
                    chk("grant", WIDTH'(req_ready), WIDTH'(NREQ'(1) << mg));
                end
            end
            if (obusOut_want && obusOut_can) begin
                if (exp_xfer_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL xfer: unexpected transfer obusOut=%h", obusOut);
                end else begin
                    mp = exp_xfer_q.pop_front();
                    chk("xfer", obusOut, mp);
                end
            end
            if (drop_err) begin
                if (exp_drop_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL drop: unexpected drop_err");
                end else begin
                    mg = exp_drop_q.pop_front();
                    chk("drop", WIDTH'(1), WIDTH'(1));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pl[0] = 82'h155;
        pl[1] = 82'h3_FFFF_0000_0000_0000_0001;
        pl[2] = 82'h2_1234_5678_9ABC_DEF0_1357;
        pl[3] = 82'h0_8000_0000_0000_0000_0000;
        for (int i = 0; i < int'(NREQ); i++) req_data[i*WIDTH +: WIDTH] = pl[i];
        req_valid      = 4'b1111;
        obusOut_can    = 1'b0;
        obusOut_replay = 1'b0;

        // Reset with all requesters asserting
        repeat (3) mid();
        chk("rst_ready", WIDTH'(req_ready), '0);
        chk("rst_obus", obusOut, '0);
        chk("rst_want", WIDTH'(obusOut_want), '0);
        chk("rst_drop", WIDTH'(drop_err), '0);
        chk("rst_busy", WIDTH'(busy), '0);

        // Round-robin 0,1,2,3,0 with the bus always accepting
        cyc(); rst = 1'b1; obusOut_can = 1'b1;
        exp_grant_q.push_back(0); exp_grant_q.push_back(1); exp_grant_q.push_back(2);
        exp_grant_q.push_back(3); exp_grant_q.push_back(0);
        exp_xfer_q.push_back(pl[0]); exp_xfer_q.push_back(pl[1]); exp_xfer_q.push_back(pl[2]);
        exp_xfer_q.push_back(pl[3]); exp_xfer_q.push_back(pl[0]);
        mid(); chk("rr_want_c0", WIDTH'(obusOut_want), '0);
        cyc(); mid();
        chk("rr_want_c1", WIDTH'(obusOut_want), WIDTH'(1));
        chk("rr_obus_c1", obusOut, pl[0]);
        repeat (8) cyc();
        req_valid = '0;
        repeat (2) cyc();
        mid();
        chk("rr_idle_busy", WIDTH'(busy), '0);
        chk("rr_grants", WIDTH'(grants_seen), WIDTH'(5));

        // Backpressure: five stalled SEND cycles then acceptance
        cyc(); req_valid = 4'b0001; obusOut_can = 1'b0;
        exp_grant_q.push_back(0); exp_xfer_q.push_back(pl[0]);
        mid();
        cyc(); req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            obusOut_can = (i == 5);
            mid();
            chk("bp_want", WIDTH'(obusOut_want), WIDTH'(1));
            chk("bp_obus", obusOut, 82'h155);
            chk("bp_ready", WIDTH'(req_ready), '0);
            cyc();
        end
        obusOut_can = 1'b0;
        mid();
        chk("bp_chk_want", WIDTH'(obusOut_want), '0);
        chk("bp_chk_busy", WIDTH'(busy), WIDTH'(1));
        cyc(); mid();
        chk("bp_idle_busy", WIDTH'(busy), '0);

        // Replay twice, then complete; req2 is granted in the completing CHECK
        cyc(); req_valid = 4'b0010; obusOut_can = 1'b1; obusOut_replay = 1'b0;
        exp_grant_q.push_back(1);
        repeat (3) exp_xfer_q.push_back(pl[1]);
        exp_grant_q.push_back(2);
        mid();
        cyc(); req_valid = 4'b0100; obusOut_replay = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            mid();
            chk("rp_drop", WIDTH'(drop_err), '0);
            if (r % 2 == 0) begin
                chk("rp_chk_want", WIDTH'(obusOut_want), '0);
                chk("rp_chk_ready", WIDTH'(req_ready), '0);
            end
            cyc();
        end
        obusOut_replay = 1'b0;
        mid(); chk("rp_obus_r5", obusOut, pl[1]);
        cyc(); mid();
        chk("rp_next_grant", WIDTH'(req_ready), WIDTH'(4'b0100));
        chk("rp_drop_r6", WIDTH'(drop_err), '0);

        // Drop: eight consecutive replays of req2, req3 granted in the dropping CHECK
        cyc(); req_valid = 4'b1000; obusOut_replay = 1'b1;
        repeat (8) exp_xfer_q.push_back(pl[2]);
        exp_drop_q.push_back(1);
        exp_grant_q.push_back(3);
        exp_xfer_q.push_back(pl[3]);
        for (int k = 0; k < 16; k++) begin
            mid();
            if (k % 2 == 1) begin
                if ((k + 1) / 2 < 8) begin
                    chk("dr_drop_lo", WIDTH'(drop_err), '0);
                    chk("dr_ready_lo", WIDTH'(req_ready), '0);
                end else begin
                    chk("dr_drop_hi", WIDTH'(drop_err), WIDTH'(1));
                    chk("dr_ready_hi", WIDTH'(req_ready), WIDTH'(4'b1000));
                end
            end else begin
                chk("dr_obus", obusOut, pl[2]);
            end
            cyc();
        end
        obusOut_replay = 1'b0; req_valid = '0;
        mid();
        chk("dr_next_want", WIDTH'(obusOut_want), WIDTH'(1));
        chk("dr_next_obus", obusOut, pl[3]);
        cyc(); mid();
        chk("dr_after_drop", WIDTH'(drop_err), '0);
        cyc(); mid();
        chk("dr_idle_busy", WIDTH'(busy), '0);

`ifdef OBUS_ARB_WDOG_EN
        // 199 stalled cycles must not trip the watchdog
        cyc(); req_valid = 4'b0001; obusOut_can = 1'b0;
        exp_grant_q.push_back(0); exp_xfer_q.push_back(pl[0]);
        cyc(); req_valid = '0;
        for (int s = 1; s <= 199; s++) begin
            mid();
            if (s == 199) chk("wd_199", WIDTH'(wdog_err), '0);
            cyc();
        end
        obusOut_can = 1'b1;
        mid(); chk("wd_199_xfer", WIDTH'(wdog_err), '0);
        cyc(); cyc();
        // 200 stalled cycles trip it on the 200th, and it stays set
        req_valid = 4'b0001; obusOut_can = 1'b0;
        exp_grant_q.push_back(0); exp_xfer_q.push_back(pl[0]);
        cyc(); req_valid = '0;
        for (int s = 1; s <= 200; s++) begin
            mid();
            if (s == 199) chk("wd_pre", WIDTH'(wdog_err), '0);
            if (s == 200) chk("wd_200", WIDTH'(wdog_err), WIDTH'(1));
            cyc();
        end
        obusOut_can = 1'b1;
        mid(); chk("wd_hold_xfer", WIDTH'(wdog_err), WIDTH'(1));
        cyc(); cyc(); mid();
        chk("wd_hold_idle", WIDTH'(wdog_err), WIDTH'(1));
`endif

        cyc(); cyc(); mid();
        chk("left_xfer", WIDTH'(exp_xfer_q.size()), '0);
        chk("left_grant", WIDTH'(exp_grant_q.size()), '0);
        chk("left_drop", WIDTH'(exp_drop_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
